// File: rtl/stream_pkg.sv
// stream_pkg: shared helpers for the valid/ready stream blocks.
// Holds small elaboration-time functions used to size module-local state.
package stream_pkg;

  // Clamp a computed width to at least one bit (e.g. $clog2(1) == 0).
  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/stream_serialize.sv
// stream_serialize: width down-converter for a valid/ready stream.
// Accepts one word of PARTS x PART_WIDTH bits and emits it as PARTS narrow
// beats, least-significant part first, with olast on the final beat.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active low
//   idat  - input word (PARTS*PART_WIDTH), part k at [k*PART_WIDTH +: PART_WIDTH]
//   ivld  - input word valid
//   irdy  - input ready (combinational from ordy; a downstream skid breaks it)
//   odat  - current output beat
//   olast - final beat of a word
//   ovld  - output beat valid
//   ordy  - output ready
module stream_serialize
  import stream_pkg::*;
#(
  parameter int PARTS      = 4,
  parameter int PART_WIDTH = 13
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PARTS*PART_WIDTH-1:0] idat,
  input  logic                        ivld,
  output logic                        irdy,
  output logic [PART_WIDTH-1:0]       odat,
  output logic                        olast,
  output logic                        ovld,
  input  logic                        ordy
);

  localparam int              CNT_W = max1($clog2(PARTS));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PARTS - 1);

  generate
    if (PARTS < 1 || PART_WIDTH < 1) begin : g_bad_params
      $error("stream_serialize: PARTS and PART_WIDTH must both be >= 1");
    end
  endgenerate

  logic [PARTS*PART_WIDTH-1:0]          w;
  logic [PARTS-1:0][PART_WIDTH-1:0]     parts;
  logic [CNT_W-1:0]                     cnt;
  logic                                 full;
  logic                                 in_xfer;
  logic                                 out_xfer;

  assign parts = w;
  assign odat  = parts[cnt];
  assign ovld  = full;
  assign olast = full && (cnt == LAST);

  // Ready when empty, or when the last beat leaves this very cycle so the
  // next word loads with no bubble. Gated by rst so nothing is accepted in reset.
  assign irdy     = rst && (!full || (ordy && olast));
  assign in_xfer  = ivld && irdy;
  assign out_xfer = full && ordy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w    <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else if (in_xfer) begin
      // A load wins over the counter step; on a last-beat overlap it is the reload.
      w    <= idat;
      cnt  <= '0;
      full <= 1'b1;
    end else if (out_xfer) begin
      if (cnt == LAST) full <= 1'b0;
      else             cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_serialize.sv
module tb_stream_serialize;

  localparam int NI = 3;
  localparam int P  [NI] = '{4, 1, 3};
  localparam int PW [NI] = '{8, 13, 5};

  typedef struct {
    logic [15:0] d;
    logic        l;
  } beat_t;

  logic        clk, rst;
  logic [63:0] idat [NI];
  logic        ivld [NI];
  logic        ordy [NI];
  logic        irdy [NI];
  logic        ovld [NI];
  logic        olast[NI];
  logic [15:0] odat [NI];
  logic [7:0]  o0;
  logic [12:0] o1;
  logic [4:0]  o2;

  beat_t q[NI][$];
  int checks = 0;
  int failures = 0;

  stream_serialize #(.PARTS(4), .PART_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .idat(idat[0][31:0]), .ivld(ivld[0]), .irdy(irdy[0]),
    .odat(o0), .olast(olast[0]), .ovld(ovld[0]), .ordy(ordy[0]));
  stream_serialize #(.PARTS(1), .PART_WIDTH(13)) dut1 (
    .clk(clk), .rst(rst), .idat(idat[1][12:0]), .ivld(ivld[1]), .irdy(irdy[1]),
    .odat(o1), .olast(olast[1]), .ovld(ovld[1]), .ordy(ordy[1]));
  stream_serialize #(.PARTS(3), .PART_WIDTH(5)) dut3 (
    .clk(clk), .rst(rst), .idat(idat[2][14:0]), .ivld(ivld[2]), .irdy(irdy[2]),
    .odat(o2), .olast(olast[2]), .ovld(ovld[2]), .ordy(ordy[2]));

  assign odat[0] = 16'(o0);
  assign odat[1] = 16'(o1);
  assign odat[2] = 16'(o2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a word becomes a queue of pending beats. Ready means nothing
  // pending, or only the final beat pending and it is leaving now.
  task automatic cycle();
    #1;
    for (int i = 0; i < NI; i++) begin
      logic   ev, er;
      logic [63:0] mask;
      beat_t  b;
      ev = (q[i].size() != 0);
      er = rst && (q[i].size() == 0 || (ordy[i] && q[i].size() == 1));
      checks++;
      if (ovld[i] !== ev) begin
        failures++;
        $display("FAIL ovld inst=%0d got=%b exp=%b t=%0t", i, ovld[i], ev, $time);
      end
      checks++;
      if (irdy[i] !== er) begin
        failures++;
        $display("FAIL irdy inst=%0d got=%b exp=%b t=%0t", i, irdy[i], er, $time);
      end
      if (ev) begin
        checks++;
        if (odat[i] !== q[i][0].d || olast[i] !== q[i][0].l) begin
          failures++;
          $display("FAIL beat inst=%0d got=%h/%b exp=%h/%b t=%0t",
                   i, odat[i], olast[i], q[i][0].d, q[i][0].l, $time);
        end
        if (ordy[i]) void'(q[i].pop_front());
      end else begin
        checks++;
        if (olast[i] !== 1'b0) begin
          failures++;
          $display("FAIL olast_idle inst=%0d got=%b exp=0 t=%0t", i, olast[i], $time);
        end
      end
      if (ivld[i] && er) begin
        mask = (64'd1 << PW[i]) - 64'd1;
        for (int k = 0; k < P[i]; k++) begin
          b.d = 16'((idat[i] >> (k * PW[i])) & mask);
          b.l = (k == P[i] - 1);
          q[i].push_back(b);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    for (int i = 0; i < NI; i++) begin
      ivld[i] = 1'b0;
      ordy[i] = 1'b1;
    end
  endtask

  task automatic drain();
    idle();
    for (int n = 0; n < 20; n++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int i = 0; i < NI; i++) idat[i] = '0;
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ovld[i] !== 1'b0 || olast[i] !== 1'b0 || irdy[i] !== 1'b0 || odat[i] !== 16'd0) begin
        failures++;
        $display("FAIL reset inst=%0d got v=%b l=%b r=%b d=%h exp all 0",
                 i, ovld[i], olast[i], irdy[i], odat[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    ivld[0] = 1'b1;
    idat[0] = 64'hDDCCBBAA;
    cycle();
    ivld[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (odat[0] !== 16'(exp[k]) || olast[0] !== (k == 3) || irdy[0] !== (k == 3)) begin
        failures++;
        $display("FAIL single k=%0d got d=%h l=%b r=%b exp d=%h l=%b r=%b",
                 k, odat[0], olast[0], irdy[0], exp[k], k == 3, k == 3);
      end
      cycle();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    ivld[0] = 1'b1;
    idat[0] = 64'h44332211;
    cycle();
    idat[0] = 64'h88776655;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (ovld[0] !== 1'b1 || odat[0] !== 16'(exp[k]) || irdy[0] !== (k == 3 || k == 7)) begin
        failures++;
        $display("FAIL b2b k=%0d got v=%b d=%h r=%b exp v=1 d=%h r=%b",
                 k, ovld[0], odat[0], irdy[0], exp[k], k == 3 || k == 7);
      end
      cycle();
      if (k == 3) ivld[0] = 1'b0;
    end
    drain();
  endtask

  task automatic test_stall();
    ivld[0] = 1'b1;
    idat[0] = 64'hDDCCBBAA;
    cycle();
    ivld[0] = 1'b0;
    cycle();
    ordy[0] = 1'b0;
    ivld[0] = 1'b1;
    idat[0] = 64'h0BADF00D;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++;
      if (odat[0] !== 16'hBB || ovld[0] !== 1'b1 || irdy[0] !== 1'b0) begin
        failures++;
        $display("FAIL stall n=%0d got d=%h v=%b r=%b exp d=bb v=1 r=0",
                 n, odat[0], ovld[0], irdy[0]);
      end
      cycle();
    end
    ordy[0] = 1'b1;
    ivld[0] = 1'b0;
    cycle();
    #1;
    checks++;
    if (odat[0] !== 16'hCC || ovld[0] !== 1'b1) begin
      failures++;
      $display("FAIL stall_resume got d=%h v=%b exp d=cc v=1", odat[0], ovld[0]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    ivld[0] = 1'b1;
    idat[0] = 64'hDDCCBBAA;
    cycle();
    ivld[0] = 1'b0;
    cycle();
    cycle();
    ordy[0] = 1'b0;
    #1;
    checks++;
    if (odat[0] !== 16'hCC) begin
      failures++;
      $display("FAIL pre_reset got d=%h exp d=cc", odat[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ovld[0] !== 1'b0 || olast[0] !== 1'b0 || irdy[0] !== 1'b0 || odat[0] !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid got v=%b l=%b r=%b d=%h exp all 0",
               ovld[0], olast[0], irdy[0], odat[0]);
    end
    for (int i = 0; i < NI; i++) q[i].delete();
    @(negedge clk);
    rst = 1'b1;
    ordy[0] = 1'b1;
    ivld[0] = 1'b1;
    idat[0] = 64'h04030201;
    cycle();
    ivld[0] = 1'b0;
    #1;
    checks++;
    if (odat[0] !== 16'h01 || ovld[0] !== 1'b1) begin
      failures++;
      $display("FAIL post_reset got d=%h v=%b exp d=01 v=1", odat[0], ovld[0]);
    end
    drain();
  endtask

  task automatic test_degenerate();
    for (int n = 0; n < 300; n++) begin
      ivld[1] = 1'($urandom_range(0, 1));
      ordy[1] = 1'($urandom_range(0, 1));
      idat[1] = {$urandom, $urandom};
      #1;
      checks++;
      if (olast[1] !== ovld[1]) begin
        failures++;
        $display("FAIL degen_last n=%0d got l=%b exp l=%b", n, olast[1], ovld[1]);
      end
      cycle();
    end
    drain();
  endtask

  task automatic test_soak();
    for (int n = 0; n < 24000; n++) begin
      for (int i = 0; i < NI; i++) begin
        if (n < 4000) begin
          ivld[i] = 1'($urandom_range(0, 1));
          ordy[i] = 1'($urandom_range(0, 1));
        end else begin
          ivld[i] = ($urandom_range(0, 18) != 0);
          ordy[i] = ($urandom_range(0, 52) != 0);
        end
        idat[i] = {$urandom, $urandom};
      end
      cycle();
    end
    drain();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        failures++;
        $display("FAIL soak_drain inst=%0d pending=%0d exp 0", i, q[i].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_degenerate();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_serialize.md
# stream_serialize

Width down-converter for the AXI-Stream-style valid/ready fabric: accepts one wide word of `PARTS` × `PART_WIDTH` bits and emits it as `PARTS` consecutive narrow beats, least-significant part first, with `olast` marking the final beat. It sits directly upstream of a `skid` instance. The skid stage registers `ordy` and absorbs the combinational `ordy`→`irdy` path this block exposes, so the pair sustains full throughput with no combinational loop across the boundary.

## Interface
Parameters:
- `PARTS`, 4, number of output beats per input word; must be ≥ 1
- `PART_WIDTH`, 13, width of one output beat in bits; must be ≥ 1

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `idat`  in  `PARTS*PART_WIDTH`  input word; part k is `idat[k*PART_WIDTH +: PART_WIDTH]`
- `ivld`  in  1  input word valid
- `irdy`  out  1  input ready; a word transfers on a rising edge when `ivld && irdy`
- `odat`  out  `PART_WIDTH`  current output beat
- `olast`  out  1  high on the final beat (part `PARTS-1`) of a word
- `ovld`  out  1  output beat valid
- `ordy`  in  1  output ready; a beat transfers on a rising edge when `ovld && ordy`

## Operation
- State:
  - word register `W` (`PARTS*PART_WIDTH` bits)
  - beat counter `Cnt` (width `max(1, $clog2(PARTS))`)
  - occupancy flag `Full`
- Outputs:
  - `ovld = Full`
  - `odat = W[Cnt*PART_WIDTH +: PART_WIDTH]`
  - `olast = Full && (Cnt == PARTS-1)`
- Ready: `irdy = rst && (!Full || (ordy && olast))`. This path is combinational from `ordy` by design.
- On input transfer: `W <= idat`, `Cnt <= 0`, `Full <= 1`. This takes priority over the counter update in the same cycle.
- On output transfer, not last beat: `Cnt <= Cnt + 1`.
- On output transfer, last beat, no simultaneous input transfer: `Full <= 0`; `Cnt` unchanged.
- Simultaneous last-beat output and input transfer: the new word loads and `Cnt` returns to 0. There are no bubbles between words.
- `Cnt` never exceeds `PARTS-1`; there is no wrap-around other than the reload.
- `PARTS == 1`: every beat is last, so `olast == ovld`. The block degenerates to a one-deep register stage with full throughput.
- While `ovld && !ordy`: `odat`, `olast`, `W` and `Cnt` hold stable. The stream contract forbids retraction or change of a presented beat.
- Input-side behaviour: `ivld` may be asserted without regard to `irdy`. Input data is sampled only on transfer, so `idat` is don't-care otherwise.

## Timing
- Reset (rst=0), values asynchronous and immediate: `Full=0`, `Cnt=0`, `W=0`, so `ovld=0`, `olast=0`, `odat=0`, and `irdy=0` (gated by `rst`).
- `irdy` rises to 1 combinationally on reset release. The first transfer can occur on the first rising edge after release.
- Reset asserted mid-word: the remaining beats are discarded and no partial word is ever emitted afterwards. After release, the next accepted word starts at part 0.
- Latency: a word accepted on edge n presents part 0 from edge n (registered, visible in cycle n+1).
- Throughput with `ordy` held high: one word per `PARTS` cycles, `irdy` high only in the last-beat cycle. With `PARTS==1` or an empty block, one word per cycle.
- Backpressure: `ordy=0` stalls both `Cnt` and word acceptance. Flow resumes on the edge after `ordy` returns high.

## Structure
- Shared package `stream_pkg`: no new typedefs required.
- Local part type `logic [PART_WIDTH-1:0]` and the counter width constant stay module-local.
- No sub-module: register, counter and mux are inline.
- The downstream `skid` is instantiated by the integrator, not inside this block.
- Parameter elaboration check: `$error` if `PARTS < 1` or `PART_WIDTH < 1`.

## Test plan
- **Single word:** PARTS=4, PART_WIDTH=8, `ordy=1`, input `0xDDCCBBAA` → beats `AA,BB,CC,DD` on 4 consecutive cycles, `olast` only with `DD`, `irdy` high in the `DD` cycle.
- **Back-to-back words:** `0x44332211` then `0x88776655`, `ivld` held, `ordy=1` → 8 contiguous beats `11..88`, no `ovld` gap, second word accepted on the `44` beat edge.
- **Mid-word stall:** drop `ordy` for 5 cycles during beat `BB` of `0xDDCCBBAA` → `odat=BB`, `ovld=1`, `irdy=0` stable throughout; `CC` follows one cycle after `ordy` returns.
- **Reset mid-word:** `rst=0` while beat `CC` is presented → `ovld`, `olast`, `irdy`, `odat` go 0 immediately with no clock edge. After release, input `0x04030201` emits `01` first.
- **Degenerate width:** PARTS=1, PART_WIDTH=13, random `ivld`/`ordy` → output sequence equals input sequence, `olast==ovld` every cycle, one transfer per cycle when both are high.
- **Soak:** PARTS∈{1,2,3,4,7}, random stalls on both sides (about 1/19 and 1/53 probability), ≥15000 words through `stream_serialize`→`skid` → scoreboard matches every beat and `olast` position, with no spurious or missing beats.
